match_select: RTL and testbench

- Upstream stage of the card-clearing path in the 3x3 card-match game.
- Collects three player selections (card indices 1..9) and rejects invalid picks.
- Compares the three card symbols. On a match, packs the indices into a 12-bit clear request for the card-clearing stage and waits for its completion.
- Tracks which cards are cleared, keeps the score, and flags game over.

---
 rtl/match_pkg.sv | 36 +++
 rtl/match_select_sym_lookup.sv | 26 ++
 rtl/match_select.sv | 166 ++++++++++++++++
 tb/tb_match_select.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// match_pkg: definitions shared by the card-match selection and clearing stages.
//   - state encoding for match_select (3-bit constants)
//   - card/symbol widths, number of cards, full cleared mask
//   - helpers: legal-index test and index -> one-hot card bit
package match_pkg;

   localparam int CARD_W  = 4;
   localparam int SYM_W   = 3;
   localparam int N_CARDS = 9;
   localparam logic [N_CARDS-1:0] FULL_MASK = 9'h1FF;

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] GOT1       = 3'd1;
   localparam logic [2:0] GOT2       = 3'd2;
   localparam logic [2:0] CHECK      = 3'd3;
   localparam logic [2:0] CLEAR_REQ  = 3'd4;
   localparam logic [2:0] CLEAR_WAIT = 3'd5;
   localparam logic [2:0] MISS_HOLD  = 3'd6;
   localparam logic [2:0] GAME_OVER  = 3'd7;

   // Card indices are 1-based; 0 and 10..15 are not cards.
   function automatic logic idx_legal(input logic [CARD_W-1:0] idx);
      return (idx >= CARD_W'(1)) && (idx <= CARD_W'(N_CARDS));
   endfunction

   // One-hot mask bit for card idx (bit idx-1); all-zero for illegal indices.
   function automatic logic [N_CARDS-1:0] card_bit(input logic [CARD_W-1:0] idx);
      logic [N_CARDS-1:0] b;
      b = '0;
      for (int k = 1; k <= N_CARDS; k++) begin
         if (idx == CARD_W'(k)) b[k-1] = 1'b1;
      end
      return b;
   endfunction

endpackage

// File: rtl/match_select_sym_lookup.sv
// sym_lookup: combinational mux from a card index to its 3-bit symbol.
//   idx      in  4   card index (1..9; anything else yields symbol 0)
//   card_sym in  27  symbol table, card k at [3k-1:3k-3]
//   sym      out 3   symbol of card idx
module sym_lookup
   import match_pkg::*;
(
   input  logic [CARD_W-1:0]        idx,
   input  logic [N_CARDS*SYM_W-1:0] card_sym,
   output logic [SYM_W-1:0]         sym
);

   // Full 16-entry table so every 4-bit index has a defined entry.
   logic [SYM_W-1:0] sym_table [0:(1<<CARD_W)-1];

   for (genvar gi = 0; gi < (1 << CARD_W); gi++) begin : g_table
      if (gi >= 1 && gi <= N_CARDS) begin : g_card
         assign sym_table[gi] = card_sym[gi*SYM_W-1 -: SYM_W];
      end else begin : g_none
         assign sym_table[gi] = '0;
      end
   end

   assign sym = sym_table[idx];

endmodule

// File: rtl/match_select.sv
// match_select: collects three card picks, checks their symbols, and either
// hands a matched group to the clearing stage or holds a mismatch display.
// Tracks cleared cards, score and game over.
//   clk, reset_n    clock, synchronous active-low reset
//   sel_valid/idx   pick pulse and picked card index (1..9)
//   card_sym        27-bit symbol table (3 bits per card)
//   clear_done      level from clearing stage: group erased
//   clear_cards     {third,second,first} picked index while a clear is active
//   clear_start     one-cycle clear request pulse
//   clear_busy      clear outstanding
//   sel_count       picks held in the current group
//   mismatch        mismatch display hold active
//   reject          one-cycle pulse: last pick was ignored
//   cleared_mask    bit k-1 set = card k cleared
//   score           matched groups
//   game_over       all nine cards cleared
module match_select
   import match_pkg::*;
#(
   parameter int HOLD_CYCLES = 25000000,
   parameter int HOLD_W      = 25
)(
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       sel_valid,
   input  logic [CARD_W-1:0]          sel_idx,
   input  logic [N_CARDS*SYM_W-1:0]   card_sym,
   input  logic                       clear_done,
   output logic [3*CARD_W-1:0]        clear_cards,
   output logic                       clear_start,
   output logic                       clear_busy,
   output logic [1:0]                 sel_count,
   output logic                       mismatch,
   output logic                       reject,
   output logic [N_CARDS-1:0]         cleared_mask,
   output logic [1:0]                 score,
   output logic                       game_over
);

   logic [2:0]          state_reg, state_next;
   logic [CARD_W-1:0]   slot_reg [0:2];
   logic [CARD_W-1:0]   slot_next [0:2];
   logic [1:0]          count_reg, count_next;
   logic [HOLD_W-1:0]   hold_reg, hold_next;
   logic [N_CARDS-1:0]  mask_reg, mask_next;
   logic [1:0]          score_reg, score_next;
   logic                reject_reg, reject_next;

   logic [SYM_W-1:0]    sym [0:2];
   logic [2:0]          held_hit;
   logic                collecting;
   logic                pick_ok;
   logic                symbols_match;
   logic [N_CARDS-1:0]  group_bits;

   for (genvar gi = 0; gi < 3; gi++) begin : g_slot
      sym_lookup u_sym (
         .idx      (slot_reg[gi]),
         .card_sym (card_sym),
         .sym      (sym[gi])
      );
      // Only slots below sel_count hold live picks.
      assign held_hit[gi] = (count_reg > 2'(gi)) && (slot_reg[gi] == sel_idx);
   end

   assign collecting    = (state_reg == IDLE) || (state_reg == GOT1) || (state_reg == GOT2);
   assign pick_ok       = idx_legal(sel_idx) && ~|(card_bit(sel_idx) & mask_reg) && ~|held_hit;
   assign symbols_match = (sym[0] == sym[1]) && (sym[1] == sym[2]);
   assign group_bits    = card_bit(slot_reg[0]) | card_bit(slot_reg[1]) | card_bit(slot_reg[2]);

   always_comb begin
      state_next  = state_reg;
      slot_next   = slot_reg;
      count_next  = count_reg;
      hold_next   = hold_reg;
      mask_next   = mask_reg;
      score_next  = score_reg;
      reject_next = 1'b0;

      case (state_reg)
         IDLE, GOT1, GOT2: begin
            if (sel_valid) begin
               if (pick_ok) begin
                  slot_next[count_reg] = sel_idx;
                  count_next           = count_reg + 2'd1;
                  case (state_reg)
                     IDLE:    state_next = GOT1;
                     GOT1:    state_next = GOT2;
                     default: state_next = CHECK;
                  endcase
               end else begin
                  reject_next = 1'b1;
               end
            end
         end
         CHECK: begin
            if (symbols_match) begin
               state_next = CLEAR_REQ;
            end else begin
               // Counting down from HOLD_CYCLES-1 to 0 gives exactly HOLD_CYCLES hold cycles.
               state_next = MISS_HOLD;
               hold_next  = HOLD_W'(HOLD_CYCLES - 1);
            end
         end
         CLEAR_REQ: begin
            state_next = CLEAR_WAIT;
         end
         CLEAR_WAIT: begin
            if (clear_done) begin
               mask_next  = mask_reg | group_bits;
               score_next = (score_reg == 2'd3) ? 2'd3 : score_reg + 2'd1;
               count_next = 2'd0;
               slot_next  = '{default: '0};
               state_next = ((mask_reg | group_bits) == FULL_MASK) ? GAME_OVER : IDLE;
            end
         end
         MISS_HOLD: begin
            if (hold_reg == '0) begin
               count_next = 2'd0;
               slot_next  = '{default: '0};
               state_next = IDLE;
            end else begin
               hold_next = hold_reg - HOLD_W'(1);
            end
         end
         GAME_OVER: begin
            state_next = GAME_OVER;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         count_reg  <= 2'd0;
         hold_reg   <= '0;
         mask_reg   <= '0;
         score_reg  <= 2'd0;
         reject_reg <= 1'b0;
         for (int k = 0; k < 3; k++) slot_reg[k] <= '0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         hold_reg   <= hold_next;
         mask_reg   <= mask_next;
         score_reg  <= score_next;
         reject_reg <= reject_next;
         for (int k = 0; k < 3; k++) slot_reg[k] <= slot_next[k];
      end
   end

   // Status outputs decode directly from the registered state.
   assign clear_start  = (state_reg == CLEAR_REQ);
   assign clear_busy   = (state_reg == CLEAR_REQ) || (state_reg == CLEAR_WAIT);
   assign clear_cards  = clear_busy ? {slot_reg[2], slot_reg[1], slot_reg[0]} : '0;
   assign mismatch     = (state_reg == MISS_HOLD);
   assign game_over    = (state_reg == GAME_OVER);
   assign sel_count    = count_reg;
   assign reject       = reject_reg;
   assign cleared_mask = mask_reg;
   assign score        = score_reg;

endmodule

// File: tb/tb_match_select.sv
// tb_match_select: directed test-plan scenarios followed by randomized games,
// checked against a pick/group-level model of the selection rules.
module tb_match_select;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sel_valid = 1'b0;
   logic [3:0]  sel_idx = '0;
   logic [26:0] card_sym = '0;
   logic        clear_done = 1'b0;
   logic [11:0] clear_cards;
   logic        clear_start, clear_busy, mismatch, reject, game_over;
   logic [1:0]  sel_count, score;
   logic [8:0]  cleared_mask;

   match_select #(.HOLD_CYCLES(HOLD), .HOLD_W(3)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sel_valid    (sel_valid),
      .sel_idx      (sel_idx),
      .card_sym     (card_sym),
      .clear_done   (clear_done),
      .clear_cards  (clear_cards),
      .clear_start  (clear_start),
      .clear_busy   (clear_busy),
      .sel_count    (sel_count),
      .mismatch     (mismatch),
      .reject       (reject),
      .cleared_mask (cleared_mask),
      .score        (score),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // model state
   int         deck [1:9];
   int         held [$];
   logic [8:0] mask_m = '0;
   int         score_m = 0;
   bit         go_m = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit in_held(input int idx);
      foreach (held[k]) if (held[k] == idx) return 1'b1;
      return 1'b0;
   endfunction

   task automatic load_deck();
      for (int k = 1; k <= 9; k++) card_sym[3*k-1 -: 3] = 3'(deck[k]);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0; sel_valid = 1'b0; clear_done = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      held.delete(); mask_m = '0; score_m = 0; go_m = 1'b0;
      chk("rst_cards", clear_cards, 0);
      chk("rst_start_busy", {clear_start, clear_busy}, 0);
      chk("rst_count", sel_count, 0);
      chk("rst_miss_rej", {mismatch, reject}, 0);
      chk("rst_mask", cleared_mask, 0);
      chk("rst_score_go", {score, game_over}, 0);
      $display("reset applied");
   endtask

   // Called at the negedge right after the third pick was taken (DUT in CHECK).
   // k: cycles after the request cycle before clear_done rises.
   // abort: >=1 resets the DUT that many cycles into the clear/hold.
   task automatic resolve(input int k_in, input int abort);
      int  k, cnt, exp_busy;
      bit  match, start_seen;
      logic [11:0] exp_cards;
      logic [8:0]  mask_before;
      k = (abort >= 1) ? 40 : k_in;
      match = (deck[held[0]] == deck[held[1]]) && (deck[held[1]] == deck[held[2]]);
      exp_cards = 12'((held[2] << 8) | (held[1] << 4) | held[0]);
      mask_before = mask_m;
      chk("check_quiet", {clear_start, clear_busy, mismatch}, 0);
      @(negedge clk);
      cnt = 0; start_seen = 1'b0;
      if (match) begin
         chk("req_start", clear_start, 1);
         chk("req_cards", clear_cards, exp_cards);
         for (int i = 0; i < 60; i++) begin
            if (abort >= 1 && i == abort) begin
               apply_reset();
               return;
            end
            if (i == k) clear_done = 1'b1;
            if (!clear_busy) break;
            cnt++;
            if (i >= 1 && clear_start) start_seen = 1'b1;
            @(negedge clk);
         end
         clear_done = 1'b0;
         exp_busy = (k + 1 > 2) ? k + 1 : 2;
         chk("busy_cycles", cnt, exp_busy);
         chk("start_once", start_seen, 0);
         mask_m = mask_m | (9'b1 << (held[0]-1)) | (9'b1 << (held[1]-1)) | (9'b1 << (held[2]-1));
         if (score_m < 3) score_m++;
         go_m = (mask_m == 9'h1FF);
         held.delete();
         chk("done_mask", cleared_mask, mask_m);
         chk("done_score", score, score_m);
         chk("done_go", game_over, go_m);
         chk("done_count", sel_count, 0);
         chk("done_cards", clear_cards, 0);
         $display("group match cards=%03h busy=%0d mask=%03h score=%0d", exp_cards, cnt, mask_m, score_m);
      end else begin
         chk("miss_start", mismatch, 1);
         for (int i = 0; i < 60; i++) begin
            if (abort >= 1 && i == abort) begin
               apply_reset();
               return;
            end
            if (!mismatch) break;
            cnt++;
            if (clear_start || clear_busy) start_seen = 1'b1;
            @(negedge clk);
         end
         held.delete();
         chk("miss_width", cnt, HOLD);
         chk("miss_noclear", start_seen, 0);
         chk("miss_count", sel_count, 0);
         chk("miss_mask", cleared_mask, mask_before);
         $display("group mismatch cards=%03h hold=%0d", exp_cards, cnt);
      end
   endtask

   task automatic do_pick(input int idx, input int k, input int abort);
      bit collect, ok;
      collect = !go_m && (held.size() < 3);
      ok = collect && idx >= 1 && idx <= 9 && !mask_m[(idx >= 1 && idx <= 9) ? idx-1 : 0] && !in_held(idx);
      @(negedge clk);
      sel_valid = 1'b1; sel_idx = 4'(idx);
      @(negedge clk);
      sel_valid = 1'b0;
      if (ok) held.push_back(idx);
      chk("reject", reject, collect && !ok);
      chk("sel_count", sel_count, held.size());
      $display("pick idx=%0d accepted=%0b held=%0d", idx, ok, held.size());
      if (held.size() == 3) resolve(k, abort);
   endtask

   function automatic int choose_pick();
      int cand [$];
      int same [$];
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8) return int'($urandom_range(0, 15));
      for (int c = 1; c <= 9; c++)
         if (!mask_m[c-1] && (r < 20 || !in_held(c))) cand.push_back(c);
      if (cand.size() == 0) return 1;
      if (held.size() > 0 && r >= 45) begin
         foreach (cand[j]) if (deck[cand[j]] == deck[held[0]]) same.push_back(cand[j]);
         if (same.size() > 0) return same[$urandom_range(0, same.size()-1)];
      end
      return cand[$urandom_range(0, cand.size()-1)];
   endfunction

   task automatic random_deck();
      int perm [9];
      int s [3];
      int j, t;
      for (int i = 0; i < 9; i++) perm[i] = i + 1;
      for (int i = 8; i > 0; i--) begin
         j = int'($urandom_range(0, i));
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int g = 0; g < 3; g++) s[g] = int'($urandom_range(0, 7));
      for (int i = 0; i < 9; i++) deck[perm[i]] = s[i / 3];
      load_deck();
   endtask

   initial begin
      // directed deck: {1,5,9}=3, {2,4,6}=5, {3,7,8}=1
      deck[1] = 3; deck[5] = 3; deck[9] = 3;
      deck[2] = 5; deck[4] = 5; deck[6] = 5;
      deck[3] = 1; deck[7] = 1; deck[8] = 1;
      load_deck();
      apply_reset();

      // match group, clear_done 10 cycles after the request
      do_pick(1, 0, -1); do_pick(5, 0, -1); do_pick(9, 10, -1);
      // rejects
      do_pick(0, 0, -1); do_pick(12, 0, -1);
      do_pick(4, 0, -1); do_pick(4, 0, -1);
      do_pick(5, 0, -1);
      // mismatch: 4,2,3 -> symbols 5,5,1
      do_pick(2, 0, -1); do_pick(3, 0, -1);
      // finish the game, last group with clear_done already high
      do_pick(2, 0, -1); do_pick(4, 0, -1); do_pick(6, 3, -1);
      do_pick(3, 0, -1); do_pick(7, 0, -1); do_pick(8, 0, -1);
      do_pick(1, 0, -1); do_pick(3, 0, -1); do_pick(15, 0, -1);
      chk("go_mask_hold", cleared_mask, 9'h1FF);
      chk("go_flag_hold", game_over, 1);

      // reset mid-clear and mid-hold, then a normal match
      apply_reset();
      do_pick(1, 0, -1); do_pick(5, 0, -1); do_pick(9, 0, 3);
      do_pick(2, 0, -1); do_pick(4, 0, -1); do_pick(3, 0, 2);
      do_pick(2, 0, -1); do_pick(4, 0, -1); do_pick(6, 5, -1);

      // randomized games
      for (int g = 0; g < 4; g++) begin
         apply_reset();
         random_deck();
         for (int n = 0; n < 90 && !go_m; n++) begin
            int ab;
            ab = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 3)) : -1;
            do_pick(choose_pick(), int'($urandom_range(0, 6)), ab);
         end
         chk("game_state", game_over, go_m);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
